// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch PC unit: FSM encoding and default constants.
package fetch_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        VEC_REQ  = 2'd1,
        VEC_LOAD = 2'd2
    } fetch_state_t;

    localparam int unsigned DEF_ADDR_WIDTH   = 32;
    localparam int unsigned DEF_STEP         = 1;
    localparam int unsigned DEF_IRQ_VEC_ADDR = 1;

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Control and instruction-memory signals between the fetch PC unit and its environment.
interface fetch_pc_unit_if
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) ();

    logic [ADDR_WIDTH-1:0] prog_start_addr;
    logic                  stall;
    logic                  redirect;
    logic [ADDR_WIDTH-1:0] redirect_addr;
    logic                  irq;
    logic [ADDR_WIDTH-1:0] vec_data;
    logic [ADDR_WIDTH-1:0] fetch_addr;
    logic                  fetch_valid;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] epc;
    logic                  irq_ack;

    modport master (
        input  prog_start_addr, stall, redirect, redirect_addr, irq, vec_data,
        output fetch_addr, fetch_valid, pc, epc, irq_ack
    );

    modport slave (
        output prog_start_addr, stall, redirect, redirect_addr, irq, vec_data,
        input  fetch_addr, fetch_valid, pc, epc, irq_ack
    );

endinterface

// File: rtl/fetch_pc_unit.sv
// Program counter and fetch-address generator with redirect, stall and a
// two-cycle interrupt vector fetch (RUN -> VEC_REQ -> VEC_LOAD -> RUN).
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int unsigned STEP         = DEF_STEP,
    parameter int unsigned IRQ_VEC_ADDR = DEF_IRQ_VEC_ADDR
) (
    input  logic            clk,
    input  logic            rst,
    fetch_pc_unit_if.master bus
);

    typedef logic [ADDR_WIDTH-1:0] addr_t;

    localparam addr_t STEP_A = addr_t'(STEP);
    localparam addr_t IRQ_A  = addr_t'(IRQ_VEC_ADDR);

    fetch_state_t state_q, state_d;
    logic         boot_q;
    addr_t        pc_p0, pc_d, pc_cur;
    addr_t        fetch_addr_p1, fetch_addr_d;
    logic         vld_p1, vld_d;
    addr_t        epc_q, epc_d;
    logic         ack_q, ack_d;

    // boot_q keeps pc following prog_start_addr through reset and the first edge after it,
    // so the reset values of every flop stay constant.
    always_comb begin
        pc_cur       = boot_q ? bus.prog_start_addr : pc_p0;
        state_d      = state_q;
        pc_d         = pc_cur;
        fetch_addr_d = fetch_addr_p1;
        vld_d        = vld_p1;
        epc_d        = epc_q;
        ack_d        = 1'b0;
        if (bus.redirect) begin
            pc_d    = bus.redirect_addr;
            vld_d   = 1'b0;
            state_d = RUN;
        end else begin
            case (state_q)
                RUN: begin
                    if (bus.irq) begin
                        epc_d        = pc_cur;
                        fetch_addr_d = IRQ_A;
                        vld_d        = 1'b0;
                        state_d      = VEC_REQ;
                    end else if (!bus.stall) begin
                        fetch_addr_d = pc_cur;
                        vld_d        = 1'b1;
                        pc_d         = pc_cur + STEP_A;
                    end
                end
                VEC_REQ: state_d = VEC_LOAD;
                VEC_LOAD: begin
                    pc_d    = bus.vec_data;
                    ack_d   = 1'b1;
                    state_d = RUN;
                end
                default: state_d = RUN;
            endcase
        end
    end

    // pc -> fetch_addr stage boundary
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= RUN;
            boot_q        <= 1'b1;
            pc_p0         <= '0;
            fetch_addr_p1 <= '0;
            vld_p1        <= 1'b0;
            epc_q         <= '0;
            ack_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            boot_q        <= 1'b0;
            pc_p0         <= pc_d;
            fetch_addr_p1 <= fetch_addr_d;
            vld_p1        <= vld_d;
            epc_q         <= epc_d;
            ack_q         <= ack_d;
        end
    end

    assign bus.pc          = pc_cur;
    assign bus.fetch_addr  = fetch_addr_p1;
    assign bus.fetch_valid = vld_p1;
    assign bus.epc         = epc_q;
    assign bus.irq_ack     = ack_q;

endmodule
